dmem_responder: RTL and testbench

Data-memory responder for the processor's 64-bit load/store port. It accepts one doubleword request at a time through a valid/ready handshake and stores data in an internal 32-bit-wide array. Each access is serialized into two 32-bit beats (low word, then high word), and a single-cycle response pulse is returned. It replaces the combinational data memory model in the full-system bench, so the processor side must tolerate multi-cycle memory latency.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: 64-bit load/store responder backed by a 32-bit-wide word array.
// Each accepted doubleword request is split into a low beat and a high beat,
// followed by a single-cycle response pulse (accept-to-accept period of 4 cycles).
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake; taken when both are 1 on a rising edge
//   req_we                 1 = store, 0 = load
//   req_addr               byte address; doubleword index = req_addr[31:3]
//   req_wdata, req_wmask   store data and byte enables
//   rsp_valid              one-cycle response pulse
//   rsp_rdata, rsp_err     load data (0 for stores/errors) and out-of-range flag
module dmem_responder #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned WORDS = 2 * DEPTH;
  localparam int unsigned WAW   = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          oor_q, oor_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic [31:0]   lo_q, lo_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;

  logic           mem_we_c;
  logic [WAW-1:0] mem_addr_c;
  logic [31:0]    mem_wdata_c;
  logic [3:0]     mem_be_c;

  // Contents survive reset; zero at time 0 so simulation starts from a known image.
  logic [31:0] mem_q [WORDS] = '{default: '0};

  // Byte offset bits carry no meaning for a doubleword port.
  logic addr_unused;
  assign addr_unused = ^req_addr[2:0];

  // State and latched-request registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state, beat sequencing and array port control.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    idx_d       = idx_q;
    oor_d       = oor_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_we_c    = 1'b0;
    mem_addr_c  = {idx_q, 1'b0};
    mem_wdata_c = wdata_q[31:0];
    mem_be_c    = wmask_q[3:0];

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_LO;
          we_d    = req_we;
          idx_d   = req_addr[AW+2:3];
          oor_d   = (req_addr[31:3] >= 29'(DEPTH));
          wdata_d = req_wdata;
          wmask_d = req_wmask;
        end
      end
      S_LO: begin
        mem_we_c = we_q & ~oor_q;
        lo_d     = mem_q[mem_addr_c];
        state_d  = S_HI;
      end
      S_HI: begin
        mem_addr_c  = {idx_q, 1'b1};
        mem_wdata_c = wdata_q[63:32];
        mem_be_c    = wmask_q[7:4];
        mem_we_c    = we_q & ~oor_q;
        // Response payload is registered on the edge entering RESP.
        rdata_d     = (we_q || oor_q) ? 64'd0 : {mem_q[mem_addr_c], lo_q};
        err_d       = oor_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rdy_d = (state_d == S_IDLE);
    vld_d = (state_d == S_RESP);
  end

  // Byte-masked word write; reset forces IDLE so an aborted beat never commits.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int j = 0; j < 4; j++) begin
        if (mem_be_c[j]) begin
          mem_q[mem_addr_c][8*j +: 8] <= mem_wdata_c[8*j +: 8];
        end
      end
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against
// a byte-addressed reference memory kept in the bench.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 9;

  logic        clk;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int tests;
  int fails;

  logic [7:0] mb [DEPTH*8];

  dmem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge and follow it to completion.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, input logic hold,
                        output logic [63:0] rd, output logic er);
    logic [63:0] exp_d;
    logic        exp_e;
    int          base;
    int          n;
    exp_e = (addr[31:3] >= 29'(DEPTH));
    exp_d = 64'd0;
    base  = int'(addr[31:3]) * 8;
    if (!exp_e) begin
      for (int b = 0; b < 8; b++) begin
        if (we) begin
          if (wmask[b]) mb[base+b] = wdata[8*b +: 8];
        end else begin
          exp_d[8*b +: 8] = mb[base+b];
        end
      end
    end
    check("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    @(posedge clk);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (!hold) req_valid = 1'b0;
      // Payload noise while busy must be ignored.
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = {$urandom, $urandom};
      req_wmask = 8'($urandom);
      if (n <= 3) check("ready_busy", 64'(req_ready), 64'd0);
      if (rsp_valid) break;
    end
    check("rsp_latency", 64'(n), 64'd3);
    check("rsp_rdata", rsp_rdata, exp_d);
    check("rsp_err", 64'(rsp_err), 64'(exp_e));
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    check("rsp_pulse", 64'(rsp_valid), 64'd0);
    check("ready_back", 64'(req_ready), 64'd1);
    check("rdata_held", rsp_rdata, exp_d);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [31:0] a;
    tests     = 0;
    fails     = 0;
    nrst      = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    for (int i = 0; i < int'(DEPTH) * 8; i++) mb[i] = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_no_rsp", 64'(rsp_valid), 64'd0);
    end

    // Full store then load
    do_req(1'b1, 32'h10, 64'h1122334455667788, 8'hFF, 1'b0, rd, er);
    do_req(1'b0, 32'h10, 64'd0, 8'h00, 1'b0, rd, er);
    check("full_load", rd, 64'h1122334455667788);

    // Partial masks
    do_req(1'b1, 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, rd, er);
    do_req(1'b0, 32'h10, 64'd0, 8'h00, 1'b0, rd, er);
    check("mask_0f", rd, 64'h11223344AAAAAAAA);
    do_req(1'b1, 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h80, 1'b0, rd, er);
    do_req(1'b0, 32'h10, 64'd0, 8'h00, 1'b0, rd, er);
    check("mask_80", rd, 64'hAA223344AAAAAAAA);
    do_req(1'b1, 32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, rd, er);
    check("mask_zero_err", 64'(er), 64'd0);
    do_req(1'b0, 32'h10, 64'd0, 8'h00, 1'b0, rd, er);

    // Out of range: aliasing guard on index 0
    do_req(1'b1, 32'h0, 64'h0123456789ABCDEF, 8'hFF, 1'b0, rd, er);
    do_req(1'b1, 32'(DEPTH * 8), 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b0, rd, er);
    check("oor_store_err", 64'(er), 64'd1);
    do_req(1'b0, 32'h0, 64'd0, 8'h00, 1'b0, rd, er);
    check("no_alias", rd, 64'h0123456789ABCDEF);
    do_req(1'b0, 32'hFFFFFFF8, 64'd0, 8'h00, 1'b0, rd, er);
    check("oor_load_data", rd, 64'd0);
    check("oor_load_err", 64'(er), 64'd1);

    // Held req_valid, alternating store/load
    for (int i = 0; i < 8; i++) begin
      a = 32'(32 + 8 * ((i / 2) % 2));
      do_req((i % 2) == 0, a, {$urandom, $urandom}, 8'($urandom), 1'b1, rd, er);
    end
    req_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h8000_0000;
      else a = 32'($urandom_range(0, 7) * 8 + $urandom_range(0, 7));
      do_req(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), 1'($urandom), rd, er);
      req_valid = 1'b0;
    end

    // Reset in the HI beat of a store
    do_req(1'b1, 32'h10, 64'd0, 8'hFF, 1'b0, rd, er);
    do_req(1'b1, 32'h18, 64'h5A5A5A5A_C3C3C3C3, 8'hFF, 1'b0, rd, er);
    do_req(1'b0, 32'h18, 64'd0, 8'h00, 1'b0, rd, er);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 64'hFFFFFFFFFFFFFFFF;
    req_wmask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_valid", 64'(rsp_valid), 64'd0);
    check("abort_rdata", rsp_rdata, 64'd0);
    check("abort_err", 64'(rsp_err), 64'd0);
    for (int b = 0; b < 4; b++) mb[16+b] = 8'hFF;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_req(1'b0, 32'h10, 64'd0, 8'h00, 1'b0, rd, er);
    check("half_commit", rd, 64'h00000000FFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
